// File: rtl/gate_pkg.sv
// gate_pkg: shared width default and gate operation encoding for the gate-adder library
package gate_pkg;
  localparam int DEFAULT_WIDTH = 1;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_NOT, OP_XOR} gate_op_e;
endpackage

// File: rtl/gate_cell.sv
// gate_cell: one bitwise combinational gate chosen at elaboration by OP
module gate_cell
  import gate_pkg::*;
#(
  parameter int       WIDTH = DEFAULT_WIDTH,
  parameter gate_op_e OP    = OP_AND
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  always_comb y = OP == OP_AND ? a & b : OP == OP_OR ? a | b : OP == OP_NOT ? ~a : a ^ b;
endmodule

// File: rtl/and_or_not_gate.sv
// and_or_not_gate: combinational AND/OR/NOT with a registered copy; GATE_XOR_EN adds XOR
module and_or_not_gate
  import gate_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y_and,
  output logic [WIDTH-1:0] y_or,
  output logic [WIDTH-1:0] y_not,
  output logic [WIDTH-1:0] q_and,
  output logic [WIDTH-1:0] q_or,
  output logic [WIDTH-1:0] q_not,
`ifdef GATE_XOR_EN
  output logic [WIDTH-1:0] y_xor,
  output logic [WIDTH-1:0] q_xor,
`endif
  output logic             q_valid
);
  gate_cell #(.WIDTH(WIDTH), .OP(OP_AND)) u_and (.a(a), .b(b), .y(y_and));
  gate_cell #(.WIDTH(WIDTH), .OP(OP_OR))  u_or  (.a(a), .b(b), .y(y_or));
  gate_cell #(.WIDTH(WIDTH), .OP(OP_NOT)) u_not (.a(a), .b(b), .y(y_not));
`ifdef GATE_XOR_EN
  gate_cell #(.WIDTH(WIDTH), .OP(OP_XOR)) u_xor (.a(a), .b(b), .y(y_xor));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_xor <= '0;
    else if (en) q_xor <= y_xor;
`endif
  // reset clears q_not to 0 rather than ~a so the register is a plain clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_and   <= '0;
      q_or    <= '0;
      q_not   <= '0;
      q_valid <= 1'b0;
    end else begin
      if (en) begin
        q_and <= y_and;
        q_or  <= y_or;
        q_not <= y_not;
      end
      q_valid <= en;
    end
endmodule

// File: tb/tb_and_or_not_gate.sv
// tb_and_or_not_gate: scoreboard bench for and_or_not_gate (8-bit and 1-bit instances; honours GATE_XOR_EN)
module tb_and_or_not_gate;
  typedef struct packed {
    logic [7:0] a, b, e_and, e_or, e_not, e_xor;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [7:0] y_and, y_or, y_not, q_and, q_or, q_not;
  logic q_valid;
  logic a1 = 1'b0, b1 = 1'b0;
  logic y1_and, y1_or, y1_not, q1_and, q1_or, q1_not, q1_valid;
`ifdef GATE_XOR_EN
  logic [7:0] y_xor, q_xor;
  logic y1_xor, q1_xor;
`endif
  int checks = 0, errors = 0;
  vec_t sb[$];

  always #5 clk = ~clk;

  and_or_not_gate #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
    .y_and(y_and), .y_or(y_or), .y_not(y_not),
    .q_and(q_and), .q_or(q_or), .q_not(q_not),
`ifdef GATE_XOR_EN
    .y_xor(y_xor), .q_xor(q_xor),
`endif
    .q_valid(q_valid)
  );

  and_or_not_gate #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a1), .b(b1),
    .y_and(y1_and), .y_or(y1_or), .y_not(y1_not),
    .q_and(q1_and), .q_or(q1_or), .q_not(q1_not),
`ifdef GATE_XOR_EN
    .y_xor(y1_xor), .q_xor(q1_xor),
`endif
    .q_valid(q1_valid)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_comb(input vec_t v);
    check("y_and", y_and, v.e_and);
    check("y_or", y_or, v.e_or);
    check("y_not", y_not, v.e_not);
`ifdef GATE_XOR_EN
    check("y_xor", y_xor, v.e_xor);
`endif
  endtask

  task automatic issue(input vec_t v);
    @(negedge clk);
    a = v.a; b = v.b; en = 1'b1;
    #1 check_comb(v);
    sb.push_back(v);
  endtask

  // monitor: every valid registered output must match the oldest issued vector
  always @(posedge clk) begin
    #1;
    if (q_valid) begin
      if (sb.size() == 0) begin
        check("q_valid_unexpected", {7'b0, q_valid}, 8'h00);
      end else begin
        vec_t e;
        e = sb.pop_front();
        check("q_and", q_and, e.e_and);
        check("q_or", q_or, e.e_or);
        check("q_not", q_not, e.e_not);
`ifdef GATE_XOR_EN
        check("q_xor", q_xor, e.e_xor);
`endif
      end
    end
  end

  vec_t vecs[7];
  logic [2:0] tt[4];

  initial begin
    vecs[0] = '{8'hF0, 8'h3C, 8'h30, 8'hFC, 8'h0F, 8'hCC};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
    vecs[3] = '{8'hAA, 8'h55, 8'h00, 8'hFF, 8'h55, 8'hFF};
    vecs[4] = '{8'h0F, 8'hF0, 8'h00, 8'hFF, 8'hF0, 8'hFF};
    vecs[5] = '{8'h12, 8'h34, 8'h10, 8'h36, 8'hED, 8'h26};
    vecs[6] = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hFE, 8'h01};
    // {and, or, not} indexed by {b, a}
    tt[0] = 3'b001; tt[1] = 3'b010; tt[2] = 3'b011; tt[3] = 3'b110;

    repeat (2) @(negedge clk);
    check("rst_q_and", q_and, 8'h00);
    check("rst_q_or", q_or, 8'h00);
    check("rst_q_not", q_not, 8'h00);
    check("rst_q_valid", {7'b0, q_valid}, 8'h00);

    for (int i = 0; i < 4; i++) begin
      a1 = i[0]; b1 = i[1];
      #1;
      check("y1_gates", {5'b0, y1_and, y1_or, y1_not}, {5'b0, tt[i]});
    end

    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) issue(vecs[i]);

    @(negedge clk);
    en = 1'b0; a = 8'h00; b = 8'h00;
    @(negedge clk);
    check("hold_q_and", q_and, vecs[5].e_and);
    check("hold_q_or", q_or, vecs[5].e_or);
    check("hold_q_not", q_not, vecs[5].e_not);
    check("hold_q_valid", {7'b0, q_valid}, 8'h00);

    issue(vecs[6]);
    @(negedge clk);
    en = 1'b0; a = 8'h00;
    @(negedge clk);
    check("lat_q_or", q_or, 8'h01);
    check("lat_q_valid", {7'b0, q_valid}, 8'h00);

    issue(vecs[2]);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_q_and", q_and, 8'h00);
    check("arst_q_or", q_or, 8'h00);
    check("arst_q_not", q_not, 8'h00);
    check("arst_q_valid", {7'b0, q_valid}, 8'h00);
    check_comb(vecs[2]);
    @(posedge clk);
    #2 check("arst_hold_valid", {7'b0, q_valid}, 8'h00);
    check("arst_hold_q_and", q_and, 8'h00);
    @(negedge clk);
    en = 1'b0; rst_n = 1'b1;

    issue(vecs[0]);
    @(negedge clk) en = 1'b0;

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drained", 8'(sb.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
